// File: rtl/alu.sv
// 8-bit registered ALU with 6502-style carry/overflow flags.
// Every operation is sampled on the rising clock edge and appears on the outputs one cycle later.
module alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] alu_a,
    input  logic [7:0] alu_b,
    input  logic [4:0] mode,
    input  logic       carry_in,
    output logic [7:0] alu_out,
    output logic       carry_out,
    output logic       overflow,
    output logic       zero,
    output logic       sign
);

    localparam logic [4:0] MODE_ADD   = 5'd0;
    localparam logic [4:0] MODE_AND   = 5'd1;
    localparam logic [4:0] MODE_OR    = 5'd2;
    localparam logic [4:0] MODE_EOR   = 5'd3;
    localparam logic [4:0] MODE_SR    = 5'd4;
    localparam logic [4:0] MODE_SUB   = 5'd5;
    localparam logic [4:0] MODE_SL    = 5'd6;
    localparam logic [4:0] MODE_PASSB = 5'd7;
    localparam logic [4:0] MODE_INC   = 5'd8;
    localparam logic [4:0] MODE_DEC   = 5'd9;

    logic [7:0] result_reg,   result_next;
    logic       carry_reg,    carry_next;
    logic       overflow_reg, overflow_next;
    logic       zero_reg;
    logic       sign_reg;

    // Subtraction reuses the adder with B inverted; carry_in supplies the +1 (borrow-not).
    logic [7:0] addend;
    logic [7:0] sum;
    logic [8:0] carry_chain;
    logic       add_overflow;

    assign addend         = (mode == MODE_SUB) ? ~alu_b : alu_b;
    assign carry_chain[0] = carry_in;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ripple
            assign sum[gi]           = alu_a[gi] ^ addend[gi] ^ carry_chain[gi];
            assign carry_chain[gi+1] = (alu_a[gi] & addend[gi])
                                     | (carry_chain[gi] & (alu_a[gi] ^ addend[gi]));
        end
    endgenerate

    // Operands of equal sign producing a result of the other sign overflow.
    assign add_overflow = (alu_a[7] == addend[7]) && (sum[7] != alu_a[7]);

    always_comb begin
        result_next   = sum;
        carry_next    = carry_reg;
        overflow_next = overflow_reg;
        case (mode)
            MODE_AND:   result_next = alu_a & alu_b;
            MODE_OR:    result_next = alu_a | alu_b;
            MODE_EOR:   result_next = alu_a ^ alu_b;
            MODE_SR: begin
                result_next = {carry_in, alu_a[7:1]};
                carry_next  = alu_a[0];
            end
            MODE_SL: begin
                result_next = {alu_a[6:0], carry_in};
                carry_next  = alu_a[7];
            end
            MODE_PASSB: result_next = alu_b;
            MODE_INC:   result_next = alu_a + 8'd1;
            MODE_DEC:   result_next = alu_a - 8'd1;
            default: begin
                // ADD, SUB and the unused encodings all take the adder path.
                result_next   = sum;
                carry_next    = carry_chain[8];
                overflow_next = add_overflow;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_reg   <= 8'h00;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b1;
            sign_reg     <= 1'b0;
        end else begin
            result_reg   <= result_next;
            carry_reg    <= carry_next;
            overflow_reg <= overflow_next;
            zero_reg     <= (result_next == 8'h00);
            sign_reg     <= result_next[7];
        end
    end

    assign alu_out   = result_reg;
    assign carry_out = carry_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;
    assign sign      = sign_reg;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU, including asynchronous reset mid-stream.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] mode;
    logic       carry_in;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       sign;

    int total = 0;
    int bad   = 0;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .mode      (mode),
        .carry_in  (carry_in),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
        end
    endtask

    task automatic expect_all(input string tag, input logic [7:0] r,
                              input logic c, input logic v, input logic z, input logic n);
        $display("step %s: out=%02h C=%0b V=%0b Z=%0b N=%0b (want %02h %0b %0b %0b %0b)",
                 tag, alu_out, carry_out, overflow, zero, sign, r, c, v, z, n);
        chk8({tag, ".out"}, alu_out, r);
        chk1({tag, ".C"}, carry_out, c);
        chk1({tag, ".V"}, overflow, v);
        chk1({tag, ".Z"}, zero, z);
        chk1({tag, ".N"}, sign, n);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic do_op(input logic [4:0] m, input logic [7:0] a,
                         input logic [7:0] b, input logic ci);
        @(negedge clk);
        mode = m; alu_a = a; alu_b = b; carry_in = ci;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; mode = 5'd0; alu_a = 8'h00; alu_b = 8'h00; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_all("reset", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        do_op(5'd7, 8'h00, 8'h5A, 1'b1);
        expect_all("passb_after_reset", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

        do_op(5'd0, 8'h50, 8'h50, 1'b0);
        expect_all("add_50_50", 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);

        do_op(5'd0, 8'hFF, 8'h01, 1'b0);
        expect_all("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        do_op(5'd5, 8'h50, 8'hB0, 1'b1);
        expect_all("sub_50_b0", 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);

        do_op(5'd5, 8'h05, 8'h03, 1'b1);
        expect_all("sub_05_03", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);

        do_op(5'd4, 8'h81, 8'hFF, 1'b1);
        expect_all("sr_81_ci1", 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1);

        do_op(5'd6, 8'h81, 8'h00, 1'b0);
        expect_all("sl_81_ci0", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);

        do_op(5'd0, 8'h80, 8'h80, 1'b0);
        expect_all("add_80_80", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

        do_op(5'd1, 8'hF0, 8'h0F, 1'b0);
        expect_all("and_hold", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

        do_op(5'd2, 8'h12, 8'h21, 1'b0);
        expect_all("or_12_21", 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);

        do_op(5'd3, 8'hFF, 8'h0F, 1'b0);
        expect_all("eor_ff_0f", 8'hF0, 1'b1, 1'b1, 1'b0, 1'b1);

        do_op(5'd8, 8'hFF, 8'h00, 1'b0);
        expect_all("inc_ff", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

        do_op(5'd9, 8'h00, 8'h00, 1'b0);
        expect_all("dec_00", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);

        do_op(5'd20, 8'h10, 8'h20, 1'b1);
        expect_all("mode20_as_add", 8'h31, 1'b0, 1'b0, 1'b0, 1'b0);

        do_op(5'd31, 8'h7F, 8'h01, 1'b0);
        expect_all("mode31_add_7f_01", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);

        // Inputs change before the edge; outputs must still show the previous result.
        @(negedge clk);
        mode = 5'd7; alu_b = 8'h3C;
        #2;
        chk8("latency_hold.out", alu_out, 8'h80);
        @(posedge clk);
        #1;
        expect_all("passb_3c", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);

        do_op(5'd0, 8'h7F, 8'h7F, 1'b0);
        expect_all("add_7f_7f", 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset asserted between edges must clear the outputs without a clock.
        #2;
        rst = 1'b0;
        #1;
        expect_all("async_reset", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        mode = 5'd5; alu_a = 8'h10; alu_b = 8'h01; carry_in = 1'b1;
        @(posedge clk);
        #1;
        expect_all("sub_after_reset", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

        do_op(5'd1, 8'hAA, 8'hF0, 1'b0);
        expect_all("and_hold_after_reset", 8'hA0, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
